// File: rtl/ttrng_pkg.sv
// Shared constants, types and helpers for the SR-latch entropy reader.
package ttrng_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEF_SAMPLE_DIV = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_REP_LIMIT  = 32;

  // Von Neumann pair phase: waiting for the first or the second bit of a pair.
  typedef enum logic {
    PhFirst,
    PhSecond
  } pair_phase_e;

  // Width of a counter that can hold 0..depth inclusive.
  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ttrng_reader_if.sv
// Byte read-out handshake between the reader and the pin-side consumer.
interface ttrng_reader_if;
  import ttrng_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [BYTE_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/ttrng_byte_fifo.sv
// Small synchronous byte FIFO; a push on a full FIFO is accepted when a pop
// frees the head slot in the same cycle.
module ttrng_byte_fifo
  import ttrng_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [BYTE_W-1:0]          wdata,
  input  logic                       pop,
  output logic [BYTE_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [fill_w(DEPTH)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Empty FIFO presents zero rather than stale storage.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage write; contents need no reset because reads are masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ttrng_reader.sv
// Entropy reader: synchronise raw latch bit, sample at a divided rate,
// von Neumann debias, repetition-count health test, pack bytes into a FIFO.
module ttrng_reader
  import ttrng_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            raw_bit,
  input  logic                            enable,
  ttrng_reader_if.master                  rd,
  output logic [fill_w(FIFO_DEPTH)-1:0]   fill_level,
  output logic                            overflow,
  output logic                            health_fail
);

  localparam logic [15:0] DivLast = 16'(SAMPLE_DIV - 1);
  localparam logic [7:0]  RepLast = 8'(REP_LIMIT);

  logic [1:0]        sync_q;
  logic [15:0]       div_q, div_d;
  pair_phase_e       ph_q, ph_d;
  logic              first_q, first_d;
  logic              prev_q, prev_d;
  logic [7:0]        run_q, run_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              health_q, health_d;
  logic              overflow_q;

  logic              sample, strobe, emit, emit_bit, push, pop;
  logic [BYTE_W-1:0] push_byte;
  logic              fifo_full, fifo_empty;

  assign sample = sync_q[1];
  assign strobe = enable && (div_q == DivLast);
  assign pop    = rd.rd_valid && rd.rd_ready;

  // Two-flop synchroniser for the asynchronous latch output.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw_bit};
  end

  // Sample-rate divider; held at zero while disabled.
  always_comb begin
    div_d = div_q + 16'd1;
    if (!enable || strobe) div_d = '0;
  end

  // Corrector phase, health run counter and packer next state.
  always_comb begin
    ph_d      = ph_q;
    first_d   = first_q;
    prev_d    = prev_q;
    run_d     = run_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    health_d  = health_q;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    push      = 1'b0;
    push_byte = shift_q;

    if (!enable) begin
      ph_d      = PhFirst;
      shift_d   = '0;
      bit_cnt_d = '0;
      run_d     = '0;
    end else if (strobe) begin
      prev_d = sample;
      // A zero run count means no previous sample since reset/disable.
      if (run_q == '0 || sample != prev_q) run_d = 8'd1;
      else if (run_q != RepLast)           run_d = run_q + 8'd1;
      if (run_d == RepLast) health_d = 1'b1;

      if (!health_d) begin
        unique case (ph_q)
          PhFirst: begin
            first_d = sample;
            ph_d    = PhSecond;
          end
          PhSecond: begin
            ph_d = PhFirst;
            if (first_q != sample) begin
              emit     = 1'b1;
              emit_bit = first_q;
            end
          end
          default: ph_d = PhFirst;
        endcase

        if (emit) begin
          // New bits enter at the MSB so the first bit ends up in bit 0.
          shift_d = {emit_bit, shift_q[BYTE_W-1:1]};
          if (bit_cnt_q == 3'd7) begin
            push      = 1'b1;
            push_byte = shift_d;
            shift_d   = '0;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
    end

    // A tripped health test freezes the packer until reset.
    if (health_d) begin
      ph_d      = PhFirst;
      shift_d   = '0;
      bit_cnt_d = '0;
    end
  end

  // State register for divider, corrector, packer, health and overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      ph_q       <= PhFirst;
      first_q    <= 1'b0;
      prev_q     <= 1'b0;
      run_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      health_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      ph_q       <= ph_d;
      first_q    <= first_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      health_q   <= health_d;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  ttrng_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_byte),
    .pop   (pop),
    .rdata (rd.rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_level)
  );

  assign rd.rd_valid = !fifo_empty;
  assign overflow    = overflow_q;
  assign health_fail = health_q;

endmodule
